// File: rtl/galois_lfsr_gen.sv
// Parametrised Galois LFSR with seed load, lockup FSM and period monitor.
// Optional LFSR_LOCKUP_RECOVER_EN: an enabled edge in LOCK reloads SEED.
module galois_lfsr_gen #(
  parameter int unsigned      WIDTH = 5,
  parameter logic [WIDTH-1:0] TAPS  = 5'b10100,
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] lfsr,
  output logic             bit_out,
  output logic [WIDTH-1:0] period,
  output logic             period_valid,
  output logic             lockup
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    LOCK
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] start;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] nxt;
  logic             do_step;
  logic             do_seed;
  logic             hit;

  assign bit_out = lfsr[0];
  assign nxt     = (lfsr >> 1) ^ (lfsr[0] ? TAPS : '0);
  assign hit     = do_step && (nxt == start);

  // State register
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next state and step/reseed decisions; load outranks everything
  always_comb begin
    state_nxt = state;
    do_step   = 1'b0;
    do_seed   = 1'b0;
    if (load) begin
      if (load_val == '0) state_nxt = LOCK;
      else if (en)        state_nxt = RUN;
      else                state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE, RUN: begin
          state_nxt = en ? RUN : IDLE;
          do_step   = en;
        end
        LOCK: begin
`ifdef LFSR_LOCKUP_RECOVER_EN
          if (en) begin
            do_seed   = 1'b1;
            state_nxt = RUN;
          end
`else
          state_nxt = LOCK;
`endif
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Register, start value, step counter and period monitor
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      lfsr         <= SEED;
      start        <= SEED;
      cnt          <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      lockup       <= 1'b0;
    end else begin
      period_valid <= hit;
      if (load) begin
        lfsr   <= load_val;
        start  <= load_val;
        cnt    <= '0;
        lockup <= (load_val == '0);
      end else if (do_seed) begin
        lfsr   <= SEED;
        start  <= SEED;
        cnt    <= '0;
        lockup <= 1'b0;
      end else if (do_step) begin
        lfsr <= nxt;
        if (hit) begin
          period <= cnt + WIDTH'(1);
          cnt    <= '0;
        end else begin
          cnt <= cnt + WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: doc/galois_lfsr_gen.md
# galois_lfsr_gen

Parametrised Galois LFSR generator, successor to the fixed 5-bit Galois LFSR. Adds configurable width and tap mask, clock enable, synchronous seed load, all-zero lockup detection and an on-line period monitor that reports the sequence length each time the register returns to its start value. Sits as a pseudo-random source and self-check unit in the lab's digital-system designs, driven from the common `clk`/`arst_n` pair.

## Interface
- `WIDTH`, 5, register width in bits (≥ 3).
- `TAPS`, `5'b10100`, Galois feedback mask, WIDTH bits. Bit WIDTH-1 must be 1. Default is x^5+x^3+1, maximal length, period 31.
- `SEED`, 1, reset value of the register, WIDTH bits, nonzero.
- `clk`  in  1  rising-edge clock.
- `arst_n`  in  1  reset, asynchronous, active-low.
- `en`  in  1  advance one step per cycle while high.
- `load`  in  1  synchronous seed load, priority over `en`.
- `load_val`  in  WIDTH  value loaded when `load`=1.
- `lfsr`  out  WIDTH  current register state (registered).
- `bit_out`  out  1  serial output, equals `lfsr[0]`.
- `period`  out  WIDTH  last measured period; holds between measurements.
- `period_valid`  out  1  one-cycle pulse when `period` updates.
- `lockup`  out  1  high while the register holds all zeros.

## Operation
- Step rule: fb = lfsr[0]; next = (lfsr >> 1) XOR (fb ? TAPS : 0).
- Priority each cycle: `load` > `en` > hold.
- Start value `start` (internal, WIDTH bits) is set to SEED at reset and to `load_val` on load. Step counter `cnt` (WIDTH bits) is cleared to 0 on reset and on load.
- On each step: if next == start, then `period` ← cnt+1, `period_valid` pulses, and `cnt` ← 0. Otherwise `cnt` ← cnt+1.
- FSM states:
  - IDLE: `en`=0, register holds.
  - RUN: `en`=1 and the register is nonzero.
  - LOCK: the register is zero.
- FSM transitions:
  - IDLE↔RUN follows `en`.
  - Any state → LOCK when zero is loaded.
  - LOCK exits only on a nonzero load, or via the recovery path (see Configuration).
- In LOCK, stepping is suppressed. `cnt` holds, `period_valid` stays 0, and `lockup`=1.
- Because TAPS[WIDTH-1]=1, the step function is invertible, so every nonzero state lies on a cycle. `cnt` therefore never exceeds 2^WIDTH-2 and needs no saturation logic.
- A load during a measurement discards the partial count. No `period_valid` is raised for it.

## Timing
- Reset values:
  - `lfsr`=SEED, `bit_out`=SEED[0].
  - `period`=0, `period_valid`=0, `lockup`=0.
  - FSM=IDLE, `cnt`=0, `start`=SEED.
- Reset is asynchronous and takes effect immediately, including mid-sequence. It releases synchronously to the next rising edge.
- `load` high at edge N: `lfsr`=`load_val` after edge N. The first step happens at edge N+1 if `en`=1.
- `en` high at edge N: `lfsr` shows the next value after edge N, i.e. latency 1.
- `period_valid` is asserted in the same cycle in which `lfsr` first equals `start` again. `period` is valid in that cycle and is held afterwards.
- `lockup` is registered. It rises in the cycle in which `lfsr` becomes 0.
- Simultaneous `load`+`en`: the load wins and no step occurs.

## Configuration
- `LFSR_LOCKUP_RECOVER_EN` defined:
  - In LOCK, the first edge with `en`=1 reloads SEED.
  - Also `start` ← SEED and `cnt` ← 0.
  - `lockup` drops with that load. The FSM returns to RUN.
- Not defined: LOCK persists, regardless of `en`, until a nonzero `load`.

## Test plan
- Reset, defaults, `en`=1: `lfsr` sequence is 00001→10100→01010→00101→10110 on successive edges, and `bit_out` tracks `lfsr[0]`.
- Free-run from reset, defaults: `period_valid` pulses 31 cycles after the first step with `period`=31, then again every 31 cycles.
- `load`=1 with `load_val`=5'b01101 while `en`=1: `lfsr`=01101 next cycle with no step. The partial count is discarded, and the next `period_valid` reports 31.
- Load 0: `lockup`=1 and `lfsr` stays 0 while `en`=1.
  - With `LFSR_LOCKUP_RECOVER_EN`: `lfsr`=00001 after the next enabled edge and `lockup`=0.
  - Without it: `lfsr` stays 0 until `load_val`=00011 is loaded.
- Non-maximal case, `WIDTH`=4, `TAPS`=4'b1111 (x^4+x^3+x^2+x+1): measured `period`=5 from seed 0001.
- Assert `arst_n`=0 mid-run, asynchronously between edges: `lfsr` returns to SEED and `period`/`period_valid`/`lockup` go to 0 immediately.
